fc_prim_seq_tx: RTL and testbench
=================================

FC_PRIM_SEQ_TX -- requirements
Module: fc_prim_seq_tx

Interface
REQ-001 SHALL have parameter LANES, default 1, meaning 32-bit words emitted per cycle; legal values 1, 2, 4.
REQ-002 SHALL have parameter MIN_REPEAT, default 8, meaning ordered sets of a sequence sent before a change is allowed; legal range 1..255.
REQ-003 SHALL have parameter FILL_IDLE, default 0, meaning STATE_AC fill word: 0 = fc::ARBFF, 1 = fc::IDLE.
REQ-004 SHALL have port clk  input  1  sole clock; all logic on its rising edge.
REQ-005 SHALL have port reset_n  input  1  synchronous, active-low reset.
REQ-006 SHALL have port state  input  fc::state_t  requested link state from the port state machine.
REQ-007 SHALL have port tx_ready  input  1  downstream accepts the current data/datak this cycle.
REQ-008 SHALL have port data  output  32*LANES  transmitted words; lane 0 in bits [31:0].
REQ-009 SHALL have port datak  output  4*LANES  K-flags, 4 bits per lane, lane 0 in bits [3:0].
REQ-010 SHALL have port active_state  output  fc::state_t  state whose sequence is currently on data.
REQ-011 SHALL have port seq_min_met  output  1  current sequence has been sent >= MIN_REPEAT times.
REQ-012 SHALL have port seq_change  output  1  one-cycle pulse: active_state updated at this edge.

Function
REQ-013 SHALL decode active_state to one ordered set: AC -> fill word (REQ-003), LR1 -> fc::LR, LR2 -> fc::LRR, LR3 -> fc::IDLE, LF1 -> fc::OLS, LF2 -> fc::NOS, OL1 -> fc::OLS, OL2 -> fc::LR, OL3 -> fc::NOS, any other -> fc::IDLE.
REQ-014 SHALL drive the same ordered set on every lane and datak = 4'b1000 on every lane.
REQ-015 SHALL derive data/datak only from registered active_state; no combinational path from state to data.
REQ-016 SHALL keep a counter cnt, width clog2(MIN_REPEAT+1), counting accepted ordered sets of the current sequence.
REQ-017 SHALL, on a cycle with tx_ready=1 and no switch, set cnt <= min(cnt + LANES, MIN_REPEAT) (saturating, never wraps).
REQ-018 SHALL drive seq_min_met = (cnt >= MIN_REPEAT), combinationally from cnt.
REQ-019 SHALL switch when tx_ready=1 AND state != active_state AND seq_min_met=1: active_state <= state, cnt <= 0, seq_change <= 1 for the following cycle.
REQ-020 SHALL transmit the old sequence on the switch cycle; the new sequence appears on data the cycle after (latency 1 from switch decision).
REQ-021 SHALL, when tx_ready=0, hold active_state, cnt and data unchanged and perform no switch even if state differs.
REQ-022 SHALL ignore state changes while seq_min_met=0; only the state value present on the switch cycle is adopted (intermediate values are dropped).
REQ-023 SHALL not switch or reset cnt if state returns to active_state before the switch condition is met.
REQ-024 SHALL allow back-to-back switches only after MIN_REPEAT accepted sets of each intervening sequence.
REQ-025 SHALL keep seq_change = 0 in all cycles except the one following a switch.

Reset
REQ-026 SHALL, while reset_n=0 at a clk edge, set active_state = fc::STATE_LF2, cnt = 0, seq_change = 0; outputs then read data = fc::NOS on all lanes, datak = 4'b1000 per lane, seq_min_met = 0.
REQ-027 SHALL, on reset asserted mid-sequence or on a switch cycle, discard the pending switch and apply REQ-026 values at that edge.
REQ-028 SHALL, after reset release, require MIN_REPEAT accepted NOS sets before leaving STATE_LF2.

Verification
REQ-029 SHALL cover: LANES=1, MIN_REPEAT=4, reset then state=LR1, tx_ready=1 -> NOS for 4 cycles, seq_change pulse, LR on cycle 6, seq_min_met low until 4 LR accepted.
REQ-030 SHALL cover: LANES=1, MIN_REPEAT=4, tx_ready toggling 1,0 with state=OL1 from reset -> switch after 4 accepted cycles (8 clk), data frozen on tx_ready=0 cycles.
REQ-031 SHALL cover: LANES=4, MIN_REPEAT=8 -> cnt saturates at 8 after 2 accepted cycles, all four lanes equal, datak = 16'h8888.
REQ-032 SHALL cover: state glitches LF2->LR1->LF2 within min-repeat window -> no seq_change, NOS continuous, cnt not cleared.
REQ-033 SHALL cover: FILL_IDLE=0 vs 1 with state=AC -> data = fc::ARBFF vs fc::IDLE; undefined state encoding -> fc::IDLE.
REQ-034 SHALL cover: reset_n asserted on a switch cycle -> next cycle active_state = STATE_LF2, data = fc::NOS, seq_change = 0.

Source files
------------

// File: rtl/fc_prim_seq_tx.sv
// Fibre Channel primitive-sequence transmitter.
// The fc package holds the link-state encoding and the ordered-set words;
// the module repeats the ordered set of the active link state on every lane
// and only moves to a newly requested state once the current sequence has
// been accepted downstream at least MIN_REPEAT times.

package fc;

    // Link states requested by the port state machine
    typedef enum logic [3:0] {
        STATE_AC  = 4'd0,
        STATE_LR1 = 4'd1,
        STATE_LR2 = 4'd2,
        STATE_LR3 = 4'd3,
        STATE_LF1 = 4'd4,
        STATE_LF2 = 4'd5,
        STATE_OL1 = 4'd6,
        STATE_OL2 = 4'd7,
        STATE_OL3 = 4'd8
    } state_t;

    // Ordered sets; K28.5 sits in the most significant byte
    localparam logic [31:0] IDLE  = 32'hBC95_B5B5;  // K28.5 D21.4 D21.5 D21.5
    localparam logic [31:0] ARBFF = 32'hBC94_FFFF;  // K28.5 D20.4 D31.7 D31.7
    localparam logic [31:0] LR    = 32'hBC49_BF49;  // K28.5 D9.2  D31.5 D9.2
    localparam logic [31:0] LRR   = 32'hBC35_BF49;  // K28.5 D21.1 D31.5 D9.2
    localparam logic [31:0] OLS   = 32'hBC35_8A55;  // K28.5 D21.1 D10.4 D21.2
    localparam logic [31:0] NOS   = 32'hBC55_BF45;  // K28.5 D21.2 D31.5 D5.2

endpackage

module fc_prim_seq_tx #(
    parameter int LANES      = 1,
    parameter int MIN_REPEAT = 8,
    parameter int FILL_IDLE  = 0
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  fc::state_t            state,
    input  logic                  tx_ready,
    output logic [32*LANES-1:0]   data,
    output logic [4*LANES-1:0]    datak,
    output fc::state_t            active_state,
    output logic                  seq_min_met,
    output logic                  seq_change
);

    // Counter wide enough to hold MIN_REPEAT; the sum gets three spare bits
    // so adding up to four lanes can never overflow before saturation.
    localparam int CW = $clog2(MIN_REPEAT + 1);
    localparam int SW = CW + 3;
    localparam logic [SW-1:0] MAX_CNT  = SW'(MIN_REPEAT);
    localparam logic [SW-1:0] LANE_INC = SW'(LANES);
    localparam logic [CW-1:0] SAT_CNT  = CW'(MIN_REPEAT);
    localparam logic [31:0]   FILL_OS  = (FILL_IDLE != 0) ? fc::IDLE : fc::ARBFF;

    logic [CW-1:0] cnt;
    logic [CW-1:0] cnt_next;
    logic [SW-1:0] cnt_sum;
    fc::state_t    active_next;
    logic          change_next;
    logic          switch_now;
    logic [31:0]   ord_set;

    assign seq_min_met = ({3'b000, cnt} >= MAX_CNT);

    // Next-state logic: switch when accepted, requested state differs and the
    // current sequence has been repeated enough; otherwise count accepted sets
    always_comb begin
        active_next = active_state;
        cnt_next    = cnt;
        change_next = 1'b0;
        cnt_sum     = {3'b000, cnt} + LANE_INC;
        switch_now  = tx_ready && (state != active_state) && seq_min_met;
        if (switch_now) begin
            active_next = state;
            cnt_next    = '0;
            change_next = 1'b1;
        end else if (tx_ready) begin
            if (cnt_sum >= MAX_CNT) begin
                cnt_next = SAT_CNT;
            end else begin
                cnt_next = cnt_sum[CW-1:0];
            end
        end
    end

    // State register; reset parks the link in LF2 sending NOS
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            active_state <= fc::STATE_LF2;
            cnt          <= '0;
            seq_change   <= 1'b0;
        end else begin
            active_state <= active_next;
            cnt          <= cnt_next;
            seq_change   <= change_next;
        end
    end

    // Ordered-set decode from the registered state only, so data never
    // follows the requested state combinationally
    always_comb begin
        ord_set = fc::IDLE;
        case (active_state)
            fc::STATE_AC:  ord_set = FILL_OS;
            fc::STATE_LR1: ord_set = fc::LR;
            fc::STATE_LR2: ord_set = fc::LRR;
            fc::STATE_LR3: ord_set = fc::IDLE;
            fc::STATE_LF1: ord_set = fc::OLS;
            fc::STATE_LF2: ord_set = fc::NOS;
            fc::STATE_OL1: ord_set = fc::OLS;
            fc::STATE_OL2: ord_set = fc::LR;
            fc::STATE_OL3: ord_set = fc::NOS;
            default:       ord_set = fc::IDLE;
        endcase
    end

    assign data  = {LANES{ord_set}};
    assign datak = {LANES{4'b1000}};

endmodule

// File: tb/tb_fc_prim_seq_tx.sv
// Directed bench for fc_prim_seq_tx: one single-lane instance with
// MIN_REPEAT=4 and ARBFF fill, one four-lane instance with MIN_REPEAT=8
// and IDLE fill, both on the same clock.
module tb_fc_prim_seq_tx;

    localparam logic [31:0] NOS   = 32'hBC55_BF45;
    localparam logic [31:0] LR    = 32'hBC49_BF49;
    localparam logic [31:0] OLS   = 32'hBC35_8A55;
    localparam logic [31:0] IDLE  = 32'hBC95_B5B5;
    localparam logic [31:0] ARBFF = 32'hBC94_FFFF;

    logic clk = 1'b0;

    logic        reset_a = 1'b0;
    fc::state_t  state_a = fc::STATE_LF2;
    logic        ready_a = 1'b0;
    logic [31:0] data_a;
    logic [3:0]  datak_a;
    fc::state_t  act_a;
    logic        met_a;
    logic        chg_a;

    logic         reset_b = 1'b0;
    fc::state_t   state_b = fc::STATE_LF2;
    logic         ready_b = 1'b0;
    logic [127:0] data_b;
    logic [15:0]  datak_b;
    fc::state_t   act_b;
    logic         met_b;
    logic         chg_b;

    int checks = 0;
    int errors = 0;

    fc_prim_seq_tx #(.LANES(1), .MIN_REPEAT(4), .FILL_IDLE(0)) dut_a (
        .clk(clk), .reset_n(reset_a), .state(state_a), .tx_ready(ready_a),
        .data(data_a), .datak(datak_a), .active_state(act_a),
        .seq_min_met(met_a), .seq_change(chg_a)
    );

    fc_prim_seq_tx #(.LANES(4), .MIN_REPEAT(8), .FILL_IDLE(1)) dut_b (
        .clk(clk), .reset_n(reset_b), .state(state_b), .tx_ready(ready_b),
        .data(data_b), .datak(datak_b), .active_state(act_b),
        .seq_min_met(met_b), .seq_change(chg_b)
    );

    // Free-running clock, period 10
    always #5 clk = ~clk;

    task automatic applyStimulusA(input logic rn, input fc::state_t st, input logic rdy);
        reset_a = rn;
        state_a = st;
        ready_a = rdy;
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulusB(input logic rn, input fc::state_t st, input logic rdy);
        reset_b = rn;
        state_b = st;
        ready_b = rdy;
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic checkA(input string tag, input logic [31:0] os, input fc::state_t act,
                          input logic met, input logic chg);
        checkOutput({tag, ".data"},  128'(data_a),  128'(os));
        checkOutput({tag, ".datak"}, 128'(datak_a), 128'(4'b1000));
        checkOutput({tag, ".act"},   128'(act_a),   128'(act));
        checkOutput({tag, ".met"},   128'(met_a),   128'(met));
        checkOutput({tag, ".chg"},   128'(chg_a),   128'(chg));
    endtask

    task automatic checkB(input string tag, input logic [31:0] os, input fc::state_t act,
                          input logic met, input logic chg);
        logic [127:0] exp_data;
        exp_data = {os, os, os, os};
        checkOutput({tag, ".data"},  data_b,           exp_data);
        checkOutput({tag, ".datak"}, 128'(datak_b),    128'(16'h8888));
        checkOutput({tag, ".act"},   128'(act_b),      128'(act));
        checkOutput({tag, ".met"},   128'(met_b),      128'(met));
        checkOutput({tag, ".chg"},   128'(chg_b),      128'(chg));
    endtask

    initial begin
        // Reset then LR1 requested: five NOS cycles, then LR with a pulse
        applyStimulusA(1'b0, fc::STATE_LR1, 1'b1);
        checkA("a_rst", NOS, fc::STATE_LF2, 1'b0, 1'b0);
        for (int i = 1; i <= 3; i++) begin
            applyStimulusA(1'b1, fc::STATE_LR1, 1'b1);
            checkA("a_nos", NOS, fc::STATE_LF2, 1'b0, 1'b0);
        end
        applyStimulusA(1'b1, fc::STATE_LR1, 1'b1);
        checkA("a_nos_met", NOS, fc::STATE_LF2, 1'b1, 1'b0);
        applyStimulusA(1'b1, fc::STATE_LR1, 1'b1);
        checkA("a_sw_lr", LR, fc::STATE_LR1, 1'b0, 1'b1);
        for (int i = 1; i <= 3; i++) begin
            applyStimulusA(1'b1, fc::STATE_LR1, 1'b1);
            checkA("a_lr", LR, fc::STATE_LR1, 1'b0, 1'b0);
        end
        applyStimulusA(1'b1, fc::STATE_LR1, 1'b1);
        checkA("a_lr_met", LR, fc::STATE_LR1, 1'b1, 1'b0);

        // tx_ready toggling with OL1 requested: data frozen on stall cycles
        applyStimulusA(1'b0, fc::STATE_OL1, 1'b1);
        checkA("b_rst", NOS, fc::STATE_LF2, 1'b0, 1'b0);
        for (int i = 0; i <= 7; i++) begin
            applyStimulusA(1'b1, fc::STATE_OL1, (i % 2) == 0);
            checkA("b_toggle", NOS, fc::STATE_LF2, i >= 6, 1'b0);
        end
        applyStimulusA(1'b1, fc::STATE_OL1, 1'b1);
        checkA("b_sw_ols", OLS, fc::STATE_OL1, 1'b0, 1'b1);

        // Glitch LF2->LR1->LF2 inside the window: no switch, count kept
        applyStimulusA(1'b0, fc::STATE_LF2, 1'b1);
        checkA("c_rst", NOS, fc::STATE_LF2, 1'b0, 1'b0);
        applyStimulusA(1'b1, fc::STATE_LR1, 1'b1);
        checkA("c_g1", NOS, fc::STATE_LF2, 1'b0, 1'b0);
        applyStimulusA(1'b1, fc::STATE_LR1, 1'b1);
        checkA("c_g2", NOS, fc::STATE_LF2, 1'b0, 1'b0);
        applyStimulusA(1'b1, fc::STATE_LF2, 1'b1);
        checkA("c_g3", NOS, fc::STATE_LF2, 1'b0, 1'b0);
        applyStimulusA(1'b1, fc::STATE_LF2, 1'b1);
        checkA("c_g4", NOS, fc::STATE_LF2, 1'b1, 1'b0);
        applyStimulusA(1'b1, fc::STATE_LF2, 1'b1);
        checkA("c_hold", NOS, fc::STATE_LF2, 1'b1, 1'b0);

        // Undefined state encoding decodes to IDLE, then AC gives ARBFF
        applyStimulusA(1'b1, fc::state_t'(4'hF), 1'b1);
        checkA("d_undef", IDLE, fc::state_t'(4'hF), 1'b0, 1'b1);
        for (int i = 1; i <= 4; i++) begin
            applyStimulusA(1'b1, fc::STATE_AC, 1'b1);
            checkA("d_undef_hold", IDLE, fc::state_t'(4'hF), i == 4, 1'b0);
        end
        applyStimulusA(1'b1, fc::STATE_AC, 1'b1);
        checkA("d_ac_arbff", ARBFF, fc::STATE_AC, 1'b0, 1'b1);

        // Reset landing on a switch cycle discards the pending switch
        for (int i = 1; i <= 4; i++) begin
            applyStimulusA(1'b1, fc::STATE_AC, 1'b1);
        end
        checkA("e_pre", ARBFF, fc::STATE_AC, 1'b1, 1'b0);
        applyStimulusA(1'b0, fc::STATE_OL2, 1'b1);
        checkA("e_rst_sw", NOS, fc::STATE_LF2, 1'b0, 1'b0);
        applyStimulusA(1'b1, fc::STATE_OL2, 1'b1);
        checkA("e_after", NOS, fc::STATE_LF2, 1'b0, 1'b0);

        // Four lanes, MIN_REPEAT=8, IDLE fill: count steps by 4 and saturates
        applyStimulusB(1'b0, fc::STATE_AC, 1'b1);
        checkB("f_rst", NOS, fc::STATE_LF2, 1'b0, 1'b0);
        applyStimulusB(1'b1, fc::STATE_AC, 1'b1);
        checkB("f_cnt4", NOS, fc::STATE_LF2, 1'b0, 1'b0);
        applyStimulusB(1'b1, fc::STATE_AC, 1'b1);
        checkB("f_cnt8", NOS, fc::STATE_LF2, 1'b1, 1'b0);
        applyStimulusB(1'b1, fc::STATE_AC, 1'b1);
        checkB("f_sw_idle", IDLE, fc::STATE_AC, 1'b0, 1'b1);
        applyStimulusB(1'b1, fc::STATE_AC, 1'b1);
        checkB("f_ac4", IDLE, fc::STATE_AC, 1'b0, 1'b0);
        for (int i = 1; i <= 3; i++) begin
            applyStimulusB(1'b1, fc::STATE_AC, 1'b1);
            checkB("f_sat", IDLE, fc::STATE_AC, 1'b1, 1'b0);
        end
        applyStimulusB(1'b1, fc::STATE_LR1, 1'b0);
        checkB("f_stall", IDLE, fc::STATE_AC, 1'b1, 1'b0);
        applyStimulusB(1'b1, fc::STATE_LR1, 1'b1);
        checkB("f_sw_lr", LR, fc::STATE_LR1, 1'b0, 1'b1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
